// File: rtl/instruction_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_pkg
//   Shared definitions for the instruction fetch stage:
//     - fetch FSM state type (RUN / HALT)
//     - HALT opcode pattern (class field [15:14], function field [7:4])
//     - default NOP word and default address width
//     - helper that recognises a HALT word
// ---------------------------------------------------------------------------
package instruction_fetch_stage_pkg;

  localparam int          DEFAULT_ADDR_W    = 16;
  localparam logic [15:0] DEFAULT_NOP_INSTR = 16'hC0E0;

  localparam logic [1:0]  HALT_CLASS = 2'b11;
  localparam logic [3:0]  HALT_FUNC  = 4'b1111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  // A HALT is identified by its class and function fields only; the
  // remaining bits are don't-care.
  function automatic logic is_halt_word(input logic [15:0] word);
    return (word[15:14] == HALT_CLASS) && (word[7:4] == HALT_FUNC);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Owns the program counter (next address to issue), the pending address
//   (address issued last cycle) and the instruction-memory address mux.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   i_run            in   fetch FSM is in RUN (HALT freezes this unit)
//   i_stall          in   downstream hold request
//   i_branch_taken   in   redirect pulse
//   i_branch_target  in   redirect address
//   o_imem_addr      out  combinational instruction-memory read address
//   o_pend_addr      out  address whose data arrives on imem_rdata this cycle
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [ADDR_W-1:0] o_pend_addr
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              w_branch;
  logic              w_hold;

  // Branch and stall only matter while running; in HALT both are ignored.
  assign w_branch = i_run & i_branch_taken;
  assign w_hold   = i_run & i_stall;

  // NOTE: every path of a combinational block must assign its outputs
  // (here via the default first), otherwise a latch is inferred.
  always_comb begin
    o_imem_addr = r_pc;
    if (w_branch) begin
      o_imem_addr = i_branch_target;
    end else if (w_hold) begin
      // Re-read the pending word so its data is still on imem_rdata when
      // the stall is released.
      o_imem_addr = r_pend_addr;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pend_addr <= RESET_PC;
    end else if (w_branch) begin
      r_pc        <= i_branch_target + ADDR_ONE;
      r_pend_addr <= i_branch_target;
    end else if (i_run && !i_stall) begin
      r_pc        <= r_pc + ADDR_ONE;
      r_pend_addr <= r_pc;
    end
  end

  assign o_pend_addr = r_pend_addr;

endmodule

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage in front of the instruction decoder. Issues addresses to a
//   synchronous instruction memory (1-cycle read latency) and captures the
//   returned word in the instruction register that drives the decoder's op
//   input. Handles sequential advance, stalls, taken-branch redirect with
//   squash, and sticky HALT detection.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   stall          in   downstream hold; freezes the stage
//   branch_taken   in   one-cycle redirect pulse (overrides stall)
//   branch_target  in   redirect address
//   imem_addr      out  instruction-memory read address (combinational)
//   imem_rdata     in   memory data for the address issued last cycle
//   op             out  instruction register (NOP_INSTR when not valid)
//   op_pc          out  address of the instruction in op
//   op_valid       out  op holds a real, non-squashed instruction
//   halted         out  HALT reached; sticky until reset
// ---------------------------------------------------------------------------
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       op,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_valid,
  output logic              halted
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_fetch_valid;
  logic              w_fetch_valid_nxt;
  logic [15:0]       r_op;
  logic [15:0]       w_op_nxt;
  logic [ADDR_W-1:0] r_op_pc;
  logic [ADDR_W-1:0] w_op_pc_nxt;
  logic              r_op_valid;
  logic              w_op_valid_nxt;
  logic              r_halted;
  logic              w_halted_nxt;

  logic              w_run;
  logic [ADDR_W-1:0] w_pend_addr;

  assign w_run = (r_state == ST_RUN);

  fetch_pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk             (clk),
    .rst             (rst),
    .i_run           (w_run),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_imem_addr     (imem_addr),
    .o_pend_addr     (w_pend_addr)
  );

  // Next-state / next-register logic. Defaults hold everything, which is
  // exactly the stall behaviour.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_valid_nxt = r_fetch_valid;
    w_op_nxt          = r_op;
    w_op_pc_nxt       = r_op_pc;
    w_op_valid_nxt    = r_op_valid;
    w_halted_nxt      = r_halted;

    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          // Squash whatever arrives this cycle; the target word is the
          // next one wanted.
          w_fetch_valid_nxt = 1'b1;
          w_op_nxt          = NOP_INSTR;
          w_op_valid_nxt    = 1'b0;
        end else if (!stall) begin
          w_fetch_valid_nxt = 1'b1;
          if (r_fetch_valid) begin
            w_op_nxt       = imem_rdata;
            w_op_pc_nxt    = w_pend_addr;
            w_op_valid_nxt = 1'b1;
            if (is_halt_word(imem_rdata)) begin
              w_state_nxt       = ST_HALT;
              w_halted_nxt      = 1'b1;
              w_fetch_valid_nxt = 1'b0;
            end
          end else begin
            w_op_nxt       = NOP_INSTR;
            w_op_valid_nxt = 1'b0;
          end
        end
      end
      ST_HALT: begin
        // HALT word stays visible for one cycle, then the register idles.
        w_op_nxt       = NOP_INSTR;
        w_op_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_fetch_valid <= 1'b0;
      r_op          <= NOP_INSTR;
      r_op_pc       <= '0;
      r_op_valid    <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_op          <= w_op_nxt;
      r_op_pc       <= w_op_pc_nxt;
      r_op_valid    <= w_op_valid_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign op       = r_op;
  assign op_pc    = r_op_pc;
  assign op_valid = r_op_valid;
  assign halted   = r_halted;

endmodule
